// File: rtl/zap_wb_slave_mem_pkg.sv
// Shared Wishbone cycle-type codes and responder FSM encoding for zap_wb_slave_mem.
package zap_wb_slave_mem_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } wb_state_t;

  // Any cycle type other than an incrementing burst ends the transfer after this beat.
  function automatic logic cti_last_beat(input logic [2:0] cti);
    return (cti == CTI_CLASSIC) || (cti == CTI_EOB) || (cti != CTI_INCR);
  endfunction

endpackage

// File: rtl/zap_ram_simple_be.sv
// Single-port synchronous RAM, four byte-write lanes, registered read (1 cycle).
// No backpressure; write and read share the one address each cycle.
module zap_ram_simple_be #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdat,
  output logic [31:0]   o_rdat
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    for (int n = 0; n < 4; n++) begin
      if (i_we && i_be[n]) begin
        mem[i_addr][8*n +: 8] <= i_wdat[8*n +: 8];
      end
    end
    o_rdat <= mem[i_addr];
  end

endmodule

// File: rtl/zap_wb_slave_mem.sv
// Wishbone B3 responder RAM: first ack 1+WAIT_STATES cycles after strobe, then one burst beat per cycle.
// Initiator stalls are not supported mid-burst; dropping cyc aborts, and a gap cycle follows every final ack.
module zap_wb_slave_mem
  import zap_wb_slave_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_wen,
  input  logic [3:0]  i_wb_sel,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [2:0]  i_wb_cti,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_ack,
  output logic        o_wb_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

  wb_state_t     state, state_nxt;
  logic [AW-1:0] idx_r, idx_nxt;
  logic          err_r, err_nxt;
  logic          gap_r, gap_nxt;
  logic [3:0]    cnt_r, cnt_nxt;
  logic          req, in_range, burst_go, ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_rdat;

  assign req      = i_wb_cyc & i_wb_stb & ~gap_r;
  assign in_range = (i_wb_adr[31:AW+2] == '0) && (i_wb_adr[1:0] == 2'b00);
  assign burst_go = i_wb_cyc & i_wb_stb & ~err_r & ~cti_last_beat(i_wb_cti);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= ST_IDLE;
      idx_r <= '0;
      err_r <= 1'b0;
      gap_r <= 1'b0;
      cnt_r <= '0;
    end else begin
      state <= state_nxt;
      idx_r <= idx_nxt;
      err_r <= err_nxt;
      gap_r <= gap_nxt;
      cnt_r <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx_r;
    err_nxt   = err_r;
    cnt_nxt   = cnt_r;
    gap_nxt   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (req) begin
          idx_nxt = i_wb_adr[AW+1:2];
          err_nxt = ~in_range;
          if (WAIT_STATES == 0) begin
            state_nxt = ST_ACK;
          end else begin
            state_nxt = ST_WAIT;
            cnt_nxt   = 4'(WAIT_STATES);
          end
        end
      end
      ST_WAIT: begin
        if (!i_wb_cyc) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt_r == 4'd1) begin
          state_nxt = ST_ACK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_r - 4'd1;
        end
      end
      ST_ACK: begin
        if (burst_go) begin
          // Stepping past the top word errors the next beat rather than wrapping.
          idx_nxt = idx_r + AW'(1);
          err_nxt = (idx_r == LAST_IDX);
        end else begin
          state_nxt = ST_IDLE;
          gap_nxt   = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_wb_ack = 1'b0;
    o_wb_err = 1'b0;
    if (state == ST_ACK && i_wb_cyc) begin
      o_wb_ack = ~err_r;
      o_wb_err = err_r;
    end
    ram_we = o_wb_ack & i_wb_wen;
    // IDLE reads the incoming word so a zero-wait ack already carries data.
    ram_addr = idx_r;
    if (state == ST_IDLE) begin
      ram_addr = i_wb_adr[AW+1:2];
    end else if (state == ST_ACK && !ram_we && burst_go) begin
      ram_addr = idx_r + AW'(1);
    end
    o_wb_dat = o_wb_ack ? ram_rdat : 32'h0;
  end

  zap_ram_simple_be #(
    .DEPTH(DEPTH_WORDS),
    .AW   (AW)
  ) u_ram (
    .i_clk  (i_clk),
    .i_we   (ram_we),
    .i_be   (i_wb_sel),
    .i_addr (ram_addr),
    .i_wdat (i_wb_dat),
    .o_rdat (ram_rdat)
  );

endmodule

// File: tb/tb_zap_wb_slave_mem.sv
// Bench for zap_wb_slave_mem: two instances (0 and 3 wait states) against a word-array reference model.
module tb_zap_wb_slave_mem;
  import zap_wb_slave_mem_pkg::*;

  localparam int DEPTH = 256;
  localparam int WS1   = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, wen = 1'b0, dsel = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0, wdat = 32'h0;
  logic [2:0]  cti = 3'b000;
  logic        cyc0, cyc1, ack0, err0, ack1, err1;
  logic [31:0] dat0, dat1;
  logic        cur_ack, cur_err;
  logic [31:0] cur_dat;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] model [2][DEPTH];

  assign cyc0    = cyc & ~dsel;
  assign cyc1    = cyc & dsel;
  assign cur_ack = dsel ? ack1 : ack0;
  assign cur_err = dsel ? err1 : err0;
  assign cur_dat = dsel ? dat1 : dat0;

  always #5 clk = ~clk;

  zap_wb_slave_mem #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_wb_cyc(cyc0), .i_wb_stb(stb), .i_wb_wen(wen),
    .i_wb_sel(sel), .i_wb_adr(adr), .i_wb_dat(wdat), .i_wb_cti(cti),
    .o_wb_dat(dat0), .o_wb_ack(ack0), .o_wb_err(err0));

  zap_wb_slave_mem #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS1)) u_dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_wb_cyc(cyc1), .i_wb_stb(stb), .i_wb_wen(wen),
    .i_wb_sel(sel), .i_wb_adr(adr), .i_wb_dat(wdat), .i_wb_cti(cti),
    .o_wb_dat(dat1), .o_wb_ack(ack1), .o_wb_err(err1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int n = 0; n < 4; n++) if (s[n]) r[8*n +: 8] = nw[8*n +: 8];
    return r;
  endfunction

  function automatic int exp_lat();
    return dsel ? 1 + WS1 : 1;
  endfunction

  // Cycles from the strobe cycle to the first response; -1 if none within the bound.
  task automatic wait_resp(output int lat);
    lat = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (cur_ack || cur_err) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic classic(input string tag, input logic w, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d, output logic [31:0] rd);
    int   lat, idx;
    logic ok;
    ok  = (a[1:0] == 2'b00) && ((a >> 2) < DEPTH);
    idx = int'(a >> 2);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; wen = w; adr = a; sel = s; wdat = d; cti = CTI_CLASSIC;
    wait_resp(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat()));
    chk({tag, "_resp"}, 32'({cur_err, cur_ack}), ok ? 32'd1 : 32'd2);
    rd = cur_dat;
    if (!ok) chk({tag, "_errdat"}, cur_dat, 32'h0);
    else if (!w) chk({tag, "_rdat"}, cur_dat, model[dsel][idx]);
    if (ok && w) model[dsel][idx] = merge(model[dsel][idx], d, s);
    // Keep the strobe up one more cycle: the responder must not ack again.
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_width"}, 32'({cur_err, cur_ack}), 32'd0);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; wen = 1'b0;
  endtask

  task automatic burst(input string tag, input logic w, input logic [31:0] a, input int n);
    int   lat, idx;
    logic ok;
    idx = int'(a >> 2);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; wen = w; adr = a; sel = 4'hF; wdat = $urandom;
    cti = (n == 1) ? CTI_EOB : CTI_INCR;
    wait_resp(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat()));
    for (int b = 0; b < n; b++) begin
      ok = (idx + b) < DEPTH;
      if (b > 0) @(negedge clk);
      chk({tag, "_resp"}, 32'({cur_err, cur_ack}), ok ? 32'd1 : 32'd2);
      if (!ok) begin
        chk({tag, "_errdat"}, cur_dat, 32'h0);
        break;
      end
      if (w) model[dsel][idx + b] = wdat;
      else chk({tag, "_rdat"}, cur_dat, model[dsel][idx + b]);
      if (b == n - 1) break;
      @(posedge clk); #1;
      wdat = $urandom;
      adr  = adr + 32'd4;
      cti  = (b + 1 == n - 1) ? CTI_EOB : CTI_INCR;
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; wen = 1'b0; cti = CTI_CLASSIC;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, a;
    int          lat, r, r2, n;
    logic        saw;

    #3;
    chk("rst_ack0", 32'(ack0), 32'd0);
    chk("rst_err0", 32'(err0), 32'd0);
    chk("rst_dat0", dat0, 32'h0);
    chk("rst_ack1", 32'(ack1), 32'd0);
    chk("rst_err1", 32'(err1), 32'd0);
    chk("rst_dat1", dat1, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    dsel = 1'b0; burst("init0", 1'b1, 32'h0, DEPTH);
    dsel = 1'b1; burst("init1", 1'b1, 32'h0, DEPTH);

    dsel = 1'b0;
    classic("wr10", 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, rd);
    classic("rd10", 1'b0, 32'h10, 4'hF, 32'h0, rd);
    chk("rd10_const", rd, 32'hDEAD_BEEF);

    classic("wr20", 1'b1, 32'h20, 4'hF, 32'hAAAA_AAAA, rd);
    classic("wr20b", 1'b1, 32'h20, 4'b0101, 32'h1122_3344, rd);
    classic("rd20", 1'b0, 32'h20, 4'b0011, 32'h0, rd);
    chk("rd20_const", rd, 32'hAA22_AA44);

    for (int i = 0; i < 4; i++) classic("wr100", 1'b1, 32'h100 + 32'(4 * i), 4'hF, 32'(i + 1), rd);
    burst("burst100", 1'b0, 32'h100, 4);

    classic("err_mis", 1'b1, 32'h2, 4'hF, 32'h5555_5555, rd);
    classic("rd0_after_err", 1'b0, 32'h0, 4'hF, 32'h0, rd);
    classic("err_oor", 1'b0, 32'(DEPTH * 4), 4'hF, 32'h0, rd);
    burst("burst_top", 1'b0, 32'((DEPTH - 1) * 4), 2);

    // Reset arrives during the third beat of a write burst to words 16..19.
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; wen = 1'b1; adr = 32'h40; sel = 4'hF; cti = CTI_INCR;
    wdat = 32'h1000_0000;
    wait_resp(lat);
    chk("rstb_lat", 32'(lat), 32'd1);
    chk("rstb_b0", 32'({err0, ack0}), 32'd1);
    model[0][16] = wdat;
    @(posedge clk); #1;
    wdat = 32'h1000_0001;
    @(negedge clk);
    chk("rstb_b1", 32'({err0, ack0}), 32'd1);
    model[0][17] = wdat;
    @(posedge clk); #1;
    wdat = 32'h1000_0002;
    #2;
    chk("rstb_b2_pre", 32'({err0, ack0}), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstb_b2_drop", 32'({err0, ack0}), 32'd0);
    chk("rstb_b2_dat", dat0, 32'h0);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; wen = 1'b0; cti = CTI_CLASSIC;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) classic("rd_after_rst", 1'b0, 32'h40 + 32'(4 * i), 4'hF, 32'h0, rd);

    // Wait-state instance: abort during the wait, then a normal read.
    dsel = 1'b1;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; wen = 1'b0; adr = 32'h0; sel = 4'hF; cti = CTI_CLASSIC;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    saw = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ack1 || err1) saw = 1'b1;
    end
    chk("abort_noack", 32'(saw), 32'd0);
    classic("ws_rd0", 1'b0, 32'h0, 4'hF, 32'h0, rd);
    burst("ws_burst", 1'b0, 32'h80, 3);

    for (int t = 0; t < 200; t++) begin
      dsel = 1'($urandom_range(0, 1));
      r    = $urandom_range(0, 99);
      if (r < 80) begin
        a  = 32'($urandom_range(0, DEPTH - 1)) << 2;
        r2 = $urandom_range(0, 19);
        if (r2 == 0) a[1:0] = 2'($urandom_range(1, 3));
        else if (r2 == 1) a = 32'($urandom_range(DEPTH, DEPTH + 100)) << 2;
        else if (r2 == 2) a[31] = 1'b1;
        classic("rnd", 1'($urandom), a, 4'($urandom), $urandom, rd);
      end else begin
        n = $urandom_range(2, 6);
        a = 32'($urandom_range(0, DEPTH + 1)) << 2;
        if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(DEPTH - 4, DEPTH - 1)) << 2;
        burst("rndb", 1'($urandom), a, n);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/zap_wb_slave_mem.md
Name: zap_wb_slave_mem

Overview:
- Wishbone B3 responder (slave) memory; serves the initiator side of the MMU walker, caches and store buffer.
- Holds page-table descriptors and data words in a word-addressed, byte-writable array.
- Registered ack/err, programmable initial wait states, and incrementing-burst support via CTI.
- Used as on-chip RAM and as the memory model for page-walk and cache verification.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, ≥16.
- WAIT_STATES, 0, extra cycles (0..15) inserted before the first ack of each transaction.

Ports:
- i_clk  in  1  core clock.
- i_reset_n  in  1  reset, asynchronous assert, active-low.
- i_wb_cyc  in  1  bus cycle.
- i_wb_stb  in  1  strobe.
- i_wb_wen  in  1  1 = write, 0 = read.
- i_wb_sel  in  4  byte selects; bit n enables byte lane [8n+7:8n].
- i_wb_adr  in  32  byte address.
- i_wb_dat  in  32  write data.
- i_wb_cti  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end-of-burst.
- o_wb_dat  out  32  read data; valid only while o_wb_ack=1.
- o_wb_ack  out  1  normal termination.
- o_wb_err  out  1  error termination.

Behaviour:
- Reset: o_wb_ack=0, o_wb_err=0, o_wb_dat=0, state=IDLE, wait counter=0, applied immediately on i_reset_n low. Array contents are not reset.
- Reset mid-transaction: outputs drop asynchronously. No write commits on any edge while reset is asserted.
- Decode: word index = adr[31:2]. The access is valid when index < DEPTH_WORDS and adr[1:0]==0. Anything else gives o_wb_err instead of ack, no write, o_wb_dat=0.
- IDLE:
  - On cyc&stb sampled high, latch the word index.
  - WAIT_STATES==0: go to ACK, so the ack is visible in the cycle after the strobe (latency 1).
  - Otherwise load counter=WAIT_STATES and go to WAIT.
- WAIT:
  - Decrement the counter each cycle; go to ACK on the cycle the counter reaches 1, so latency = 1+WAIT_STATES.
  - cyc low: go to IDLE with no ack.
- ACK: o_wb_ack (or o_wb_err) high for this cycle.
  - Write: bytes with i_wb_sel[n]=1 are committed at the edge ending this cycle, using i_wb_dat/i_wb_sel presented in this cycle. sel=0000 commits nothing but still acks.
  - Read: o_wb_dat is a registered copy of mem[index]; for sel lanes that are 0, the data is still the full word.
  - i_wb_cti != 010, or cti==111 sampled this cycle, or err: go to IDLE.
  - cti==010 and cyc&stb high: stay in ACK; index+1; next beat acked the following cycle (one beat per cycle, no wait states after the first beat). The slave ignores i_wb_adr after the first beat.
  - cyc low: abort to IDLE, with no commit for the current cycle.
- IDLE does not sample stb in the cycle immediately after the final ack. This gives a mandatory one-cycle gap between classic transfers, and lets the initiator deassert stb from its ack-registered logic.
- Burst that increments past DEPTH_WORDS-1: that beat is err-terminated, no commit, then go to IDLE. The index never wraps.
- o_wb_ack and o_wb_err are never high together, and are never high while cyc is low in the same cycle. Back-to-back reads of the same address return identical data.
- A write followed by a read of the same word returns the new data; no bypass is needed because of the gap cycle.

Decomposition:
- Shared defines/localparams in the common include:
  - CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111.
  - State encodings IDLE/WAIT/ACK.
- Sub-module zap_ram_simple_be: single-port synchronous RAM, 4 byte-enable lanes, registered read. The FSM drives its address mux: the latched index, or index+1 during a burst.

Test Plan:
- Classic read, WAIT_STATES=0, mem[4]=32'hDEAD_BEEF, adr=32'h10, cti=000 → ack one cycle after stb, o_wb_dat=DEADBEEF, ack width 1 cycle.
- Byte write: adr=32'h20, sel=0101, dat=32'h1122_3344 over old 32'hAAAA_AAAA, then read adr=32'h20 → 32'hAA22_AA44.
- WAIT_STATES=3, read adr=0 → ack exactly 4 cycles after stb sampled. Drop cyc in cycle 2 → no ack, state returns to IDLE.
- Incrementing burst of 4 reads from adr=32'h100 (cti 010,010,010,111) with mem[64..67]=1,2,3,4 → four consecutive acks returning 1,2,3,4, then IDLE.
- Errors:
  - adr=32'h2 → o_wb_err, no write.
  - adr=DEPTH_WORDS*4 → o_wb_err.
  - burst starting at index DEPTH_WORDS-1 → ack for beat 0, err for beat 1.
- Assert i_reset_n low during a burst ACK cycle → ack/err low in the same cycle, no commit for that beat, first transaction after release behaves normally.
